// File: rtl/stopwatch_pkg.sv
// Stopwatch control: shared state encoding and timing defaults.
// Imported by the FSM top and the increment-button repeat unit.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } sw_state_e;

  localparam int unsigned DEF_REPEAT_DELAY = 50;
  localparam int unsigned DEF_REPEAT_RATE  = 10;
  localparam int unsigned DEF_ALARM_TICKS  = 1000;

  function automatic int cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stopwatch_btn_autorepeat.sv
// Increment button: rising-edge pulse plus hold-to-repeat.
// One instance per increment button.
module btn_autorepeat
  import stopwatch_pkg::*;
#(
  parameter int unsigned DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  input  logic en,
  input  logic rpt_en,
  input  logic blk,
  input  logic clr,
  output logic edge_det,
  output logic pulse
);

  localparam int unsigned CMAX =
    (DELAY > RATE) ? DELAY : RATE;
  localparam int CW = cnt_width(CMAX);

  logic          btn_q;
  logic          arm;
  logic          rep;
  logic          held;
  logic          hit;
  logic          fire;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign edge_det = btn & ~btn_q;

  // A button held through reset or clear never
  // arms; only a fresh press starts repeating.
  assign held = btn & (arm | edge_det)
              & en & rpt_en & ~clr;

  always_comb begin
    cnt_inc = cnt;
    if (cnt != CW'(CMAX))
      cnt_inc = cnt + CW'(1);
    hit = rep ? (cnt_inc == CW'(RATE))
              : (cnt_inc == CW'(DELAY));
    fire = en & ~blk & ~pulse
         & (edge_det | (held & tick & hit));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= btn;
      arm   <= 1'b0;
      rep   <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      btn_q <= btn;
      pulse <= fire;
      arm   <= btn & ~clr & (arm | edge_det);
      if (!held) begin
        cnt <= '0;
        rep <= 1'b0;
      end else if (tick) begin
        if (hit) begin
          cnt <= '0;
          rep <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/pause/alarm sequencing,
// direction latch and increment command pulses.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int unsigned ALARM_TICKS  = DEF_ALARM_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       clr_btn,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       min_btn,
  input  logic       hour_btn,
  input  logic       mode_sw,
  input  logic       at_zero,
  output logic       cnt_en,
  output logic       dir_down,
  output logic       clr_pulse,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       blink_en,
  output logic       alarm,
  output logic [1:0] state
);

  localparam int AW = cnt_width(ALARM_TICKS);
  localparam logic [AW-1:0] A_MAX =
    AW'(ALARM_TICKS);
  localparam logic [AW:0] A_LIM =
    (AW+1)'(ALARM_TICKS);

  sw_state_e     st_q;
  sw_state_e     st_d;
  logic          clr_q;
  logic          start_q;
  logic          stop_q;
  logic          clr_e;
  logic          start_e;
  logic          stop_e;
  logic          min_e;
  logic          hour_e;
  logic          hi_e;
  logic          any_e;
  logic          inc_ok;
  logic          zero_g;
  logic          a_hit;
  logic [AW-1:0] acnt;
  logic [AW:0]   acnt_n;

  assign clr_e   = clr_btn & ~clr_q;
  assign start_e = start_btn & ~start_q;
  assign stop_e  = stop_btn & ~stop_q;
  assign hi_e    = clr_e | stop_e | start_e;
  assign any_e   = hi_e | min_e | hour_e;
  assign inc_ok  = (st_q == S_IDLE)
                 | (st_q == S_PAUSE);
  assign zero_g  = dir_down & at_zero;
  assign acnt_n  = {1'b0, acnt} + 1'b1;
  assign a_hit   = tick & (acnt_n >= A_LIM);
  assign state   = st_q;

  btn_autorepeat #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE)
  ) u_min (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .btn      (min_btn),
    .en       (inc_ok),
    .rpt_en   (~hour_btn),
    .blk      (hi_e),
    .clr      (clr_e),
    .edge_det (min_e),
    .pulse    (min_inc)
  );

  btn_autorepeat #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE)
  ) u_hour (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .btn      (hour_btn),
    .en       (inc_ok),
    .rpt_en   (1'b1),
    .blk      (hi_e),
    .clr      (clr_e),
    .edge_det (hour_e),
    .pulse    (hour_inc)
  );

  always_comb begin
    st_d = st_q;
    if (clr_e) begin
      st_d = S_IDLE;
    end else begin
      unique case (st_q)
        S_IDLE:
          if (start_e && !zero_g)
            st_d = S_RUN;
        S_RUN:
          // Reaching zero beats a same-cycle stop.
          if (zero_g)
            st_d = S_ALARM;
          else if (stop_e)
            st_d = S_PAUSE;
        S_PAUSE:
          if (start_e && !zero_g)
            st_d = S_RUN;
        S_ALARM:
          if (any_e || a_hit)
            st_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      clr_q     <= clr_btn;
      start_q   <= start_btn;
      stop_q    <= stop_btn;
      cnt_en    <= 1'b0;
      blink_en  <= 1'b0;
      alarm     <= 1'b0;
      clr_pulse <= 1'b0;
      dir_down  <= 1'b0;
      acnt      <= '0;
    end else begin
      st_q      <= st_d;
      clr_q     <= clr_btn;
      start_q   <= start_btn;
      stop_q    <= stop_btn;
      cnt_en    <= (st_d == S_RUN);
      blink_en  <= (st_d == S_PAUSE);
      alarm     <= (st_d == S_ALARM);
      clr_pulse <= clr_e;
      if (st_q == S_IDLE)
        dir_down <= mode_sw;
      if (st_q != S_ALARM || clr_e)
        acnt <= '0;
      else if (tick && acnt != A_MAX)
        acnt <= acnt + AW'(1);
    end
  end

endmodule
